// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_port_arbiter_pkg;

  localparam int NREG   = 32;
  localparam int AW     = $clog2(NREG);
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_port_arbiter_rf_clear_walker.sv
// Register index walker for the post-reset / on-demand register file clear.
// Latency: idx advances one step per enabled cycle; done is combinational on the last index.
// Backpressure: none; the walk advances every cycle while en is high.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   en             advance idx this cycle
//   restart        force idx back to 0 on the next edge (wins over en)
//   idx            current register index being cleared
//   done           idx is the last register (NREG-1)
module rf_clear_walker
  import regfile_port_arbiter_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          restart,
  output logic [AW-1:0] idx,
  output logic          done
);

  // idx wraps from NREG-1 back to 0 on its own, so it is already 0 when
  // the next walk starts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (restart) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
    end
  end

  assign done = (idx == AW'(NREG - 1));

endmodule

// File: rtl/regfile_port_arbiter.sv
// Write-port sequencer/arbiter for the 32x32 register file: clear walk, CPU vs debug write sharing, debug read-back.
// Latency: write mux is combinational (0 cycles); debug read data is registered (1 cycle).
// Backpressure: debug writes wait via dbg_wready; after STARVE_LIMIT refused cycles the CPU is stalled for one grant.
//
// Ports:
//   clock, reset                        rising-edge clock, async active-low reset
//   cpu_we/cpu_waddr/cpu_wdata          CPU writeback request; cpu_stall freezes the CPU
//   dbg_wvalid/dbg_waddr/dbg_wdata      debug write request; dbg_wready accepts it
//   dbg_rvalid_in/dbg_raddr             debug read request; dbg_rready accepts it
//   dbg_rvalid/dbg_rdata                debug read response, one cycle later
//   rf_raddr/rf_rdata                   register file debug read port
//   rf_we/rf_waddr/rf_wdata             register file write port
//   clear_busy/clear_req                clear walk status / start a new walk
//
// Build option: REGFILE_DBG_READ_EN enables the debug read path; without it
// the read outputs are tied to zero and no read-data register exists.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              dbg_wvalid,
  input  logic [AW-1:0]     dbg_waddr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_wready,
  input  logic              dbg_rvalid_in,
  input  logic [AW-1:0]     dbg_raddr,
  output logic              dbg_rready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [AW-1:0]     rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              clear_busy,
  input  logic              clear_req
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [AW-1:0] clr_idx;
  logic          clr_done;
  logic          clr_restart;
  logic          starved;
  logic          dbg_grant;
  logic          cpu_grant;

  assign clr_restart = (state == ST_RUN) && clear_req;
  assign starved     = (starve_cnt == SW'(STARVE_LIMIT));

  rf_clear_walker u_walker (
    .clock   (clock),
    .reset   (reset),
    .en      (state == ST_CLEAR),
    .restart (clr_restart),
    .idx     (clr_idx),
    .done    (clr_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_done)  state_nxt = ST_RUN;
      ST_RUN:   if (clear_req) state_nxt = ST_CLEAR;
      default:                 state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    cpu_stall  = 1'b0;
    clear_busy = 1'b0;
    dbg_grant  = 1'b0;
    cpu_grant  = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = cpu_waddr;
    rf_wdata   = cpu_wdata;
    case (state)
      ST_CLEAR: begin
        cpu_stall  = 1'b1;
        clear_busy = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = clr_idx;
        rf_wdata   = ZERO_DATA;
      end
      default: begin
        // A clear request leaves any pending debug write unaccepted so it
        // cannot land behind the walk's back.
        if (clear_req) begin
          cpu_grant = cpu_we;
        end else if (starved && dbg_wvalid) begin
          dbg_grant = 1'b1;
          cpu_stall = 1'b1;
        end else if (cpu_we) begin
          cpu_grant = 1'b1;
        end else if (dbg_wvalid) begin
          dbg_grant = 1'b1;
        end
        if (dbg_grant) begin
          rf_waddr = dbg_waddr;
          rf_wdata = dbg_wdata;
          rf_we    = (dbg_waddr != '0);
        end else begin
          rf_we    = cpu_grant && (cpu_waddr != '0);
        end
      end
    endcase
  end

  assign dbg_wready = dbg_grant;

  // Counts cycles a waiting debug write lost to the CPU; any other outcome
  // (grant, no request, clear walk) resets the count.
  always_comb begin
    starve_nxt = '0;
    if ((state == ST_RUN) && !clear_req && cpu_grant && dbg_wvalid && !starved) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

`ifdef REGFILE_DBG_READ_EN
  // rf_rdata is sampled before this edge's write lands, so a same-cycle
  // read of the written address returns the old contents.
  assign dbg_rready = (state == ST_RUN) && dbg_rvalid_in;
  assign rf_raddr   = dbg_raddr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= ZERO_DATA;
    end else begin
      dbg_rvalid <= dbg_rready;
      if (dbg_rready) begin
        dbg_rdata <= rf_rdata;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd  = ^{dbg_rvalid_in, dbg_raddr, rf_rdata};
  assign dbg_rready = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = ZERO_DATA;
  assign rf_raddr   = '0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  localparam int LIM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_we = 1'b0, dbg_wvalid = 1'b0, dbg_rvalid_in = 1'b0, clear_req = 1'b0;
  logic [4:0]  cpu_waddr = '0, dbg_waddr = '0, dbg_raddr = '0;
  logic [31:0] cpu_wdata = '0, dbg_wdata = '0;
  logic        cpu_stall, dbg_wready, dbg_rready, dbg_rvalid, rf_we, clear_busy;
  logic [31:0] dbg_rdata, rf_rdata, rf_wdata;
  logic [4:0]  rf_raddr, rf_waddr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  regfile_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .dbg_wvalid(dbg_wvalid), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata), .dbg_wready(dbg_wready),
    .dbg_rvalid_in(dbg_rvalid_in), .dbg_raddr(dbg_raddr), .dbg_rready(dbg_rready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .clear_busy(clear_busy), .clear_req(clear_req)
  );

  // Register file the arbiter drives; combinational read port.
  logic [31:0] rf_mem [32];
  assign rf_rdata = rf_mem[rf_raddr];
  always @(posedge clock) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  // Reference model: clearing flag + walk position, refused-cycle count,
  // expected register contents and the pending read response.
  bit          m_clr;
  int          m_idx;
  int          m_ref;
  bit          m_rv;
  logic [31:0] m_rd;
  logic [31:0] m_regs [32];
  bit          obs_wready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = 1; m_idx = 0; m_ref = 0; m_rv = 0; m_rd = '0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit e_we, e_stall, e_rr, dgrant, cgrant;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, n_rd;
    @(negedge clock);
    e_we = 0; e_stall = 0; e_rr = 0; dgrant = 0; cgrant = 0; e_wa = '0; e_wd = '0;
    if (m_clr) begin
      e_we = 1; e_stall = 1; e_wa = 5'(m_idx); e_wd = '0;
    end else begin
`ifdef REGFILE_DBG_READ_EN
      e_rr = dbg_rvalid_in;
`endif
      if (clear_req)                      cgrant = cpu_we;
      else if (dbg_wvalid && m_ref == LIM) begin dgrant = 1; e_stall = 1; end
      else if (cpu_we)                    cgrant = 1;
      else if (dbg_wvalid)                dgrant = 1;
      if (dgrant) begin e_wa = dbg_waddr; e_wd = dbg_wdata; e_we = (dbg_waddr != 0); end
      else if (cgrant) begin e_wa = cpu_waddr; e_wd = cpu_wdata; e_we = (cpu_waddr != 0); end
    end
    obs_wready = dbg_wready;
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, e_wa);
      chk("rf_wdata", rf_wdata, e_wd);
    end
    chk("cpu_stall", cpu_stall, e_stall);
    chk("dbg_wready", dbg_wready, dgrant);
    chk("dbg_rready", dbg_rready, e_rr);
    chk("clear_busy", clear_busy, m_clr);
    chk("dbg_rvalid", dbg_rvalid, m_rv);
    chk("dbg_rdata", dbg_rdata, m_rd);
`ifdef REGFILE_DBG_READ_EN
    chk("rf_raddr", rf_raddr, dbg_raddr);
`else
    chk("rf_raddr", rf_raddr, 0);
`endif
    n_rd = e_rr ? m_regs[dbg_raddr] : m_rd;
    @(posedge clock);
    m_rv = e_rr;
    m_rd = n_rd;
    if (e_we) m_regs[e_wa] = e_wd;
    if (m_clr) begin
      m_ref = 0;
      m_idx++;
      if (m_idx == 32) begin m_clr = 0; m_idx = 0; end
    end else if (clear_req) begin
      m_clr = 1; m_idx = 0; m_ref = 0;
    end else if (dgrant || !dbg_wvalid) begin
      m_ref = 0;
    end else if (m_ref < LIM) begin
      m_ref++;
    end
    #1;
  endtask

  task automatic idle();
    cpu_we = 0; dbg_wvalid = 0; dbg_rvalid_in = 0; clear_req = 0;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      m_regs[i] = rf_mem[i];
    end
    model_reset();
    m_regs[0] = '0;
    #1;
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_clear_busy", clear_busy, 1);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    @(posedge clock); #1;
    reset = 1;

    // Power-up clear walk, with a debug write pending that must not be taken.
    dbg_wvalid = 1; dbg_waddr = 5'd3; dbg_wdata = 32'hDEAD_BEEF;
    repeat (32) cycle();
    idle();
    cycle();

    // Free-port debug write.
    dbg_wvalid = 1; dbg_waddr = 5'd5; dbg_wdata = 32'h1234_5678;
    cycle();
    chk("dbg_free_accept", obs_wready, 1);
    idle();

    // Continuous CPU writes with a pending debug write: granted on cycle LIM+1.
    cpu_we = 1; cpu_waddr = 5'd10; cpu_wdata = 32'hCAFE_0001;
    dbg_wvalid = 1; dbg_waddr = 5'd9; dbg_wdata = 32'h0BAD_F00D;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      lat++;
      if (obs_wready) break;
    end
    chk("starve_latency", lat, LIM + 1);
    dbg_wvalid = 0;
    cycle();

    // Address 0 is never written.
    cpu_we = 1; cpu_waddr = 5'd0; cpu_wdata = 32'hFFFF_FFFF;
    cycle();
    cpu_we = 0; dbg_wvalid = 1; dbg_waddr = 5'd0; dbg_wdata = 32'h5555_AAAA;
    cycle();
    chk("dbg_addr0_accept", obs_wready, 1);
    idle();

    // Read back addr 5, then a same-cycle read/write of addr 7.
    dbg_rvalid_in = 1; dbg_raddr = 5'd5;
    cycle();
    dbg_rvalid_in = 0;
    cycle();
    dbg_rvalid_in = 1; dbg_raddr = 5'd7; dbg_wvalid = 1; dbg_waddr = 5'd7; dbg_wdata = 32'h7777_0007;
    cycle();
    idle();
    cycle();
    dbg_rvalid_in = 1; dbg_raddr = 5'd7;
    cycle();
    idle();
    cycle();

    // clear_req in RUN with a debug write pending, then reset at walk index 17.
    clear_req = 1; dbg_wvalid = 1; dbg_waddr = 5'd4; dbg_wdata = 32'h4444_4444;
    cycle();
    idle();
    repeat (17) cycle();
    #2 reset = 0;
    #1;
    model_reset();
    chk("midrst_clear_busy", clear_busy, 1);
    chk("midrst_rf_waddr", rf_waddr, 0);
    chk("midrst_cpu_stall", cpu_stall, 1);
    @(posedge clock); @(posedge clock); #1;
    reset = 1;
    repeat (33) cycle();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      cpu_we    = ($urandom_range(0, 3) != 0);
      cpu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      if (!(dbg_wvalid && !obs_wready)) begin
        dbg_wvalid = $urandom_range(0, 1);
        dbg_waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        dbg_wdata  = $urandom;
      end
      dbg_rvalid_in = ($urandom_range(0, 2) == 0);
      dbg_raddr     = 5'($urandom_range(0, 31));
      clear_req     = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Sequencer and arbiter for the 32×32 MIPS register file write port. Runs a post-reset clear walk, shares the single write port between CPU writeback and the UART debug host, and serves debug read-back through a dedicated read address. Sits between the CPU writeback path and the register file.

## Interface
- STARVE_LIMIT, 4: consecutive refused debug-write cycles before the CPU is stalled for one grant.
- NREG, 32: register count; address width is log2(NREG) = 5.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_we  in  1  CPU writeback request (RegWrite).
- cpu_waddr  in  5  CPU destination address, already resolved for RegDst/Jal.
- cpu_wdata  in  32  CPU writeback data, already resolved for MemtoReg/Jal.
- cpu_stall  out  1  freezes the CPU PC and writeback.
- dbg_wvalid  in  1  debug write request.
- dbg_waddr  in  5  debug write address.
- dbg_wdata  in  32  debug write data.
- dbg_wready  out  1  debug write accepted this cycle.
- dbg_rvalid_in  in  1  debug read request.
- dbg_raddr  in  5  debug read address.
- dbg_rready  out  1  debug read accepted this cycle.
- dbg_rvalid  out  1  debug read data valid, one-cycle pulse.
- dbg_rdata  out  32  debug read data.
- rf_raddr  out  5  register file debug read port address.
- rf_rdata  in  32  register file debug read port data, combinational.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- clear_busy  out  1  clear walk in progress.
- clear_req  in  1  start a new clear walk (pulse).

## Operation
- States:
  - CLEAR: walks clr_idx 0..31, drives rf_we=1, rf_waddr=clr_idx, rf_wdata=0. cpu_stall=1, dbg_wready=0, dbg_rready=0. After idx 31 goes to RUN.
  - RUN: normal arbitration.
- RUN arbitration, write port mux is combinational:
  - cpu_we=1 and starve_cnt<STARVE_LIMIT: CPU owns the port. dbg_wready=0. starve_cnt increments while dbg_wvalid=1, saturating.
  - starve_cnt==STARVE_LIMIT with dbg_wvalid=1: cpu_stall=1 this cycle, debug owns the port, dbg_wready=1, starve_cnt clears.
  - cpu_we=0 and dbg_wvalid=1: debug owns the port, dbg_wready=1, starve_cnt clears.
  - dbg_wvalid=0: starve_cnt clears.
- Writes to address 0 from CPU or debug: rf_we forced 0. A debug write to address 0 is still accepted (dbg_wready=1).
- clear_req in RUN: enters CLEAR next edge with clr_idx=0. A pending debug write is not accepted in that cycle. clear_req in CLEAR is ignored.
- Debug read:
  - Always granted in RUN: dbg_rready = dbg_rvalid_in, rf_raddr = dbg_raddr.
  - rf_rdata is registered into dbg_rdata, with dbg_rvalid=1 on the next cycle.
  - Reading the address being written in the same cycle returns the old value.

## Timing
- Reset values: state=CLEAR, clr_idx=0, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0, cpu_stall=1, clear_busy=1.
- Clear walk: the first edge after reset release writes idx 0. clear_busy falls after exactly 32 write cycles.
- Reset asserted mid-walk or mid-operation: state returns to CLEAR immediately and the walk restarts at 0.
- Debug write latency: 0 cycles when the port is free, at most STARVE_LIMIT+1 cycles under continuous CPU writes.
- Debug read latency: 1 cycle.
- Simultaneous debug read and write to the same address: read returns the pre-write value.

## Configuration
- REGFILE_DBG_READ_EN defined: debug read path as specified.
- REGFILE_DBG_READ_EN undefined:
  - dbg_rready=0, dbg_rvalid=0, dbg_rdata=0, rf_raddr=0.
  - No read-data register is instantiated.
  - The write path is unchanged.

## Structure
- Shared package: the state enum (CLEAR, RUN), NREG, the address-width constant and the reset-zero data constant.
- One sub-module, rf_clear_walker: clr_idx counter, done flag and restart input.
- Arbitration, starvation counter and read capture live in the top module.

## Test plan
- Reset release → rf_we=1 for 32 cycles with rf_waddr 0..31 and rf_wdata=0; then clear_busy=0 and cpu_stall=0.
- RUN, cpu_we=0, dbg write addr 5 data 32'h1234_5678 → same cycle: dbg_wready=1, rf_waddr=5, rf_wdata=32'h1234_5678.
- cpu_we=1 held continuously plus debug write pending, STARVE_LIMIT=4 → refused 4 cycles; 5th cycle: cpu_stall=1, dbg_wready=1, debug data on rf_wdata.
- CPU write to address 0 with data 32'hFFFF_FFFF → rf_we=0. Debug write to address 0 → dbg_wready=1, rf_we=0.
- Debug read addr 5 after the write above → the next cycle has dbg_rvalid=1 and dbg_rdata=32'h1234_5678. With the macro undefined, dbg_rready=0.
- Reset asserted at clear idx 17, then released → walk restarts at idx 0 and lasts 32 cycles. clear_req in RUN → new 32-cycle walk.
